hcsr04_ctrl: RTL and testbench
==============================

Name: hcsr04_ctrl

Overview:
Measurement sequencer for the HC-SR04 ultrasonic ranging path.
- Issues the trigger pulse and times the echo pulse in microseconds.
- Presents the echo width as TIME to the distance calculator (170*TIME>>10, pipelined multiplier), waits out the multiplier latency, then captures the distance result.
- Handles echo timeouts and enforces a minimum re-trigger period.
- Sits between the sensor pins and the display/consumer logic.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; US_DIV = CLK_FREQ_HZ/1_000_000 cycles per microsecond tick.
TRIG_US, 10, trigger pulse width in microseconds.
TIMEOUT_US, 38000, maximum wait for echo rise and maximum echo high time, in microseconds.
PERIOD_US, 60000, minimum time from one trigger start to the next trigger start, in microseconds.
MULT_LAT, 3, calculator latency in cycles from TIME change to a valid dis_mm.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
en  in  1  level; while high, measurements repeat every PERIOD_US
echo  in  1  sensor echo pin, asynchronous
trig  out  1  sensor trigger pin
time_us  out  16  echo width in us, drives calculator TIME
calc_dis_mm  in  14  distance returned from calculator
dist_mm  out  14  last captured distance
dist_vld  out  1  one-cycle strobe: new dist_mm or timeout report
timeout  out  1  sticky per measurement: 1 = last measurement timed out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; trig=0, time_us=0, dist_mm=0, dist_vld=0, timeout=0, busy=0; prescaler and all counters cleared. This holds mid-operation: trig drops on the reset edge.
- echo path: 2-FF synchronizer, then edge detect on the synced signal. Rise and fall are flagged one cycle after the sync output changes.
- us tick: prescaler counts 0..US_DIV-1 and ticks when it wraps. It restarts at 0 on entry to TRIG and on echo rise.
- Period counter (us): cleared on TRIG entry, saturates at PERIOD_US.
- States:
  - IDLE: en=1 -> TRIG on the next cycle.
  - TRIG: trig=1 for exactly TRIG_US*US_DIV cycles -> WAIT_ECHO. trig is registered and low in every other state.
  - WAIT_ECHO: wait counter in us. Rise -> MEASURE. Counter reaching TIMEOUT_US -> TOUT. An echo already high on entry does not count as a rise; a stuck-high echo ends in TOUT.
  - MEASURE: width counter cleared on the rise and incremented on each tick while echo is high.
    - Fall -> time_us <= width, then CALC.
    - Width reaching TIMEOUT_US -> TOUT.
    - Result: time_us = floor(high_cycles/US_DIV).
  - CALC: time_us held stable for MULT_LAT+1 cycles. Then dist_mm <= calc_dis_mm, timeout <= 0, dist_vld=1 for one cycle -> HOLDOFF.
  - TOUT: time_us unchanged, dist_mm unchanged, timeout <= 1, dist_vld=1 for one cycle -> HOLDOFF.
  - HOLDOFF: wait for period counter >= PERIOD_US. Then en=1 -> TRIG, en=0 -> IDLE.
- en deasserted mid-measurement: the current measurement completes, including dist_vld; then IDLE.
- Widths: TIMEOUT_US and PERIOD_US must be < 65536 so all us counters are 16 bits with no wrap. Counters saturate and never wrap.
- time_us changes only on the MEASURE->CALC transition, so the calculator output is stable in all other states.
- Echo edges outside WAIT_ECHO/MEASURE are ignored.

Decomposition:
- Package hcsr04_pkg: state enum (IDLE, TRIG, WAIT_ECHO, MEASURE, CALC, TOUT, HOLDOFF); derived constants US_DIV, TRIG_CYC; counter width 16; distance width 14.
- Sub-module hcsr04_echo_sync: 2-FF synchronizer plus registered rise/fall pulses. Its reset is the same synchronous, active-high RST.
- The top level instantiates the existing distance calculator alongside, not inside, this block.

Test Plan:
- Reset mid-TRIG: assert RST while trig=1 -> trig=0 on the next edge; all outputs 0; state IDLE; busy=0.
- Nominal (100 MHz, behavioural calculator with MULT_LAT=3): en=1, echo high 588200 cycles starting 50 us after trig falls -> trig high exactly 1000 cycles; time_us=5882; dist_vld exactly 4 cycles after CALC entry with dist_mm=976; timeout=0.
- No echo: echo held 0 -> TOUT 38000 us after trig falls; dist_vld pulse; timeout=1; dist_mm keeps its previous value.
- Stuck/long echo: echo high before WAIT_ECHO and kept high -> timeout=1. Separately, echo high 40 ms after a valid rise -> timeout at width 38000 us; time_us not updated.
- Period and en: en held 1 with short echoes -> consecutive trig rises exactly 6_000_000 cycles apart. Drop en during MEASURE -> that dist_vld still fires, then IDLE, no further trig.
- Boundary widths: echo 0 cycles after a glitch-free rise (1 us) gives time_us=0 or 1 per the floor rule. Echo of exactly 100 cycles -> time_us=1, dist_mm=0. Echo of 37999 us -> valid, dist_mm=6308.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared types, widths and derived-constant helpers for the HC-SR04 sequencer.
package hcsr04_pkg;

    localparam int CNT_W  = 16;
    localparam int DIST_W = 14;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        CALC      = 3'd4,
        TOUT      = 3'd5,
        HOLDOFF   = 3'd6
    } state_t;

    function automatic int us_div_of(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

    function automatic int trig_cyc_of(input int clk_freq_hz, input int trig_us);
        return us_div_of(clk_freq_hz) * trig_us;
    endfunction

    // Microsecond counters stop at their limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 16'd1;
    endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// Echo pin synchronizer with registered rise/fall pulses on the synced level.
module hcsr04_echo_sync (
    input  logic CLK,
    input  logic RST,
    input  logic echo,
    output logic rise,
    output logic fall
);
    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Two-stage synchronizer, then edge pulses one cycle after the synced change
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= echo;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/hcsr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger, echo timing, calculator handshake,
// timeout reporting and re-trigger pacing.
module hcsr04_ctrl
    import hcsr04_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 38000,
    parameter int PERIOD_US   = 60000,
    parameter int MULT_LAT    = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic [CNT_W-1:0]  time_us,
    input  logic [DIST_W-1:0] calc_dis_mm,
    output logic [DIST_W-1:0] dist_mm,
    output logic              dist_vld,
    output logic              timeout,
    output logic              busy
);
    localparam int DIV_CYC  = us_div_of(CLK_FREQ_HZ);
    localparam int TRIG_LEN = trig_cyc_of(CLK_FREQ_HZ, TRIG_US);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYC - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_LEN - 1);
    localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] TOUT_LIM  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] PER_LIM   = CNT_W'(PERIOD_US);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  pre_r;
    logic [CNT_W-1:0]  per_pre_r;
    logic [CNT_W-1:0]  per_cnt_r;
    logic [CNT_W-1:0]  us_cnt_r;
    logic [CNT_W-1:0]  cyc_r;
    logic [CNT_W-1:0]  us_inc_s;
    logic              us_tick_s;
    logic              per_tick_s;
    logic              per_done_s;
    logic              rise_s;
    logic              fall_s;
    logic              trig_r;
    logic [CNT_W-1:0]  time_r;
    logic [DIST_W-1:0] dist_r;
    logic              vld_r;
    logic              tout_r;
    logic              busy_r;

    hcsr04_echo_sync u_echo_sync (
        .CLK  (CLK),
        .RST  (RST),
        .echo (echo),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Tick decode and look-ahead counter values used by the FSM
    always_comb begin
        us_tick_s  = (pre_r == DIV_LAST);
        per_tick_s = (per_pre_r == DIV_LAST);
        if (us_tick_s) begin
            us_inc_s = sat_inc(us_cnt_r, TOUT_LIM);
        end else begin
            us_inc_s = us_cnt_r;
        end
        // Period is judged on the value being written so re-trigger lands exactly on the boundary
        per_done_s = (per_cnt_r >= PER_LIM) ||
                     (per_tick_s && (per_cnt_r == PER_LIM - 16'd1));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:      if (en) state_s = TRIG; else state_s = IDLE;
            TRIG:      if (cyc_r == TRIG_LAST) state_s = WAIT_ECHO; else state_s = TRIG;
            WAIT_ECHO: if (rise_s)                     state_s = MEASURE;
                       else if (us_inc_s == TOUT_LIM)  state_s = TOUT;
                       else                            state_s = WAIT_ECHO;
            MEASURE:   if (fall_s)                     state_s = CALC;
                       else if (us_inc_s == TOUT_LIM)  state_s = TOUT;
                       else                            state_s = MEASURE;
            CALC:      if (cyc_r == CALC_LAST) state_s = HOLDOFF; else state_s = CALC;
            TOUT:      state_s = HOLDOFF;
            HOLDOFF:   if (per_done_s) state_s = en ? TRIG : IDLE; else state_s = HOLDOFF;
            default:   state_s = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            pre_r     <= '0;
            per_pre_r <= '0;
            per_cnt_r <= '0;
            us_cnt_r  <= '0;
            cyc_r     <= '0;
            trig_r    <= 1'b0;
            time_r    <= '0;
            dist_r    <= '0;
            vld_r     <= 1'b0;
            tout_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_s;

            if (state_s != state_r)  cyc_r <= '0;
            else if (cyc_r != '1)    cyc_r <= cyc_r + 16'd1;

            // Measurement prescaler realigns on trigger start and on echo rise
            if ((state_s == TRIG && state_r != TRIG) || (state_s == MEASURE && state_r != MEASURE))
                pre_r <= '0;
            else if (us_tick_s)
                pre_r <= '0;
            else
                pre_r <= pre_r + 16'd1;

            // Period timebase has its own prescaler so echo realignment cannot skew pacing
            if (state_s == TRIG && state_r != TRIG) begin
                per_pre_r <= '0;
                per_cnt_r <= '0;
            end else begin
                per_pre_r <= per_tick_s ? '0 : per_pre_r + 16'd1;
                if (per_tick_s) per_cnt_r <= sat_inc(per_cnt_r, PER_LIM);
            end

            if (state_s != state_r && (state_s == WAIT_ECHO || state_s == MEASURE))
                us_cnt_r <= '0;
            else if (state_r == WAIT_ECHO || state_r == MEASURE)
                us_cnt_r <= us_inc_s;

            trig_r <= (state_s == TRIG);
            busy_r <= (state_s != IDLE);
            vld_r  <= (state_r == CALC && state_s == HOLDOFF) || (state_r == TOUT);

            if (state_r == MEASURE && state_s == CALC) time_r <= us_inc_s;

            if (state_r == CALC && state_s == HOLDOFF) begin
                dist_r <= calc_dis_mm;
                tout_r <= 1'b0;
            end else if (state_r == TOUT) begin
                tout_r <= 1'b1;
            end
        end
    end

    assign trig     = trig_r;
    assign time_us  = time_r;
    assign dist_mm  = dist_r;
    assign dist_vld = vld_r;
    assign timeout  = tout_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_hcsr04_ctrl.sv
// Directed bench for hcsr04_ctrl at a scaled clock (4 cycles per us) with short timeouts.
module tb_hcsr04_ctrl;
    localparam int CLK_FREQ_HZ = 4_000_000;
    localparam int TRIG_US     = 10;
    localparam int TIMEOUT_US  = 300;
    localparam int PERIOD_US   = 600;
    localparam int MULT_LAT    = 3;

    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic        en   = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic [15:0] time_us;
    logic [13:0] calc_dis_mm;
    logic [13:0] dist_mm;
    logic        dist_vld;
    logic        timeout;
    logic        busy;
    logic [13:0] p1 = 14'd0, p2 = 14'd0, p3 = 14'd0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    hcsr04_ctrl #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TRIG_US     (TRIG_US),
        .TIMEOUT_US  (TIMEOUT_US),
        .PERIOD_US   (PERIOD_US),
        .MULT_LAT    (MULT_LAT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .echo        (echo),
        .trig        (trig),
        .time_us     (time_us),
        .calc_dis_mm (calc_dis_mm),
        .dist_mm     (dist_mm),
        .dist_vld    (dist_vld),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural calculator: 170*TIME>>10, three register stages
    always @(posedge CLK) begin
        p1 <= 14'((170 * int'(time_us)) >> 10);
        p2 <= p1;
        p3 <= p2;
    end
    assign calc_dis_mm = p3;

    task automatic wait_trig(input logic level, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge CLK); n++;
            if (trig === level) ok = 1'b1;
        end
    endtask

    task automatic wait_vld(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge CLK); n++;
            if (dist_vld === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge CLK); n++;
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Pulse en for one trigger, return on the first cycle after trig falls
    task automatic start_meas(output bit ok);
        int n; bit ok1, ok2;
        en = 1'b1;
        wait_trig(1'b1, 10, n, ok1);
        en = 1'b0;
        wait_trig(1'b0, 100, n, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic pulse_echo(input int n);
        echo = 1'b1;
        repeat (n) @(negedge CLK);
        echo = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (trig !== 1'b0)      begin errors++; $display("FAIL reset_trig got %b want 0", trig); end
        checks++; if (time_us !== 16'd0)  begin errors++; $display("FAIL reset_time got %0d want 0", time_us); end
        checks++; if (dist_mm !== 14'd0)  begin errors++; $display("FAIL reset_dist got %0d want 0", dist_mm); end
        checks++; if (dist_vld !== 1'b0)  begin errors++; $display("FAIL reset_vld got %b want 0", dist_vld); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_trig();
        en = 1'b1;
        @(negedge CLK);
        checks++; if (trig !== 1'b1) begin errors++; $display("FAIL midrst_trig_rise got %b want 1", trig); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_high got %b want 1", busy); end
        repeat (5) @(negedge CLK);
        RST = 1'b1; en = 1'b0;
        @(negedge CLK);
        checks++; if (trig !== 1'b0)     begin errors++; $display("FAIL midrst_trig got %b want 0", trig); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (time_us !== 16'd0 || dist_mm !== 14'd0 || dist_vld !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %0d/%0d/%b/%b want 0/0/0/0", time_us, dist_mm, dist_vld, timeout);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_nominal();
        int n, hi, tchg, vat, vcnt; bit ok;
        en = 1'b1;
        wait_trig(1'b1, 10, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nom_trig_start got none want trig"); end
        en = 1'b0;
        hi = 0;
        while (trig === 1'b1 && hi < 200) begin hi++; @(negedge CLK); end
        checks++; if (hi != 40) begin errors++; $display("FAIL nom_trig_width got %0d want 40", hi); end
        repeat (200) @(negedge CLK);
        pulse_echo(1000);
        tchg = -1; vat = -1; vcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (tchg < 0 && time_us !== 16'd0) tchg = i;
            if (dist_vld === 1'b1) begin vcnt++; if (vat < 0) vat = i; end
        end
        checks++; if (tchg != 4)   begin errors++; $display("FAIL nom_calc_entry got %0d want 4", tchg); end
        checks++; if (vat != 8)    begin errors++; $display("FAIL nom_vld_latency got %0d want 8", vat); end
        checks++; if (vcnt != 1)   begin errors++; $display("FAIL nom_vld_width got %0d want 1", vcnt); end
        checks++; if (time_us !== 16'd250) begin errors++; $display("FAIL nom_time got %0d want 250", time_us); end
        checks++; if (dist_mm !== 14'd41)  begin errors++; $display("FAIL nom_dist got %0d want 41", dist_mm); end
        checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL nom_timeout got %b want 0", timeout); end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nom_idle got busy want idle"); end
    endtask

    task automatic test_no_echo();
        int n; bit ok;
        start_meas(ok);
        checks++; if (!ok) begin errors++; $display("FAIL noecho_trig got none want trig"); end
        wait_vld(2000, n, ok);
        checks++; if (!ok || n != 1201) begin errors++; $display("FAIL noecho_latency got %0d want 1201", n); end
        checks++; if (timeout !== 1'b1)   begin errors++; $display("FAIL noecho_timeout got %b want 1", timeout); end
        checks++; if (dist_mm !== 14'd41) begin errors++; $display("FAIL noecho_dist got %0d want 41", dist_mm); end
        checks++; if (time_us !== 16'd250) begin errors++; $display("FAIL noecho_time got %0d want 250", time_us); end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL noecho_idle got busy want idle"); end
    endtask

    task automatic test_boundary();
        int widths [4] = '{3, 4, 7, 1196};
        int exp_t  [4] = '{0, 1, 1, 299};
        int exp_d  [4] = '{0, 0, 0, 49};
        int n; bit ok;
        for (int k = 0; k < 4; k++) begin
            start_meas(ok);
            repeat (20) @(negedge CLK);
            pulse_echo(widths[k]);
            wait_vld(50, n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL bnd%0d_vld got none want pulse", k); end
            checks++; if (int'(time_us) != exp_t[k]) begin errors++; $display("FAIL bnd%0d_time got %0d want %0d", k, time_us, exp_t[k]); end
            checks++; if (int'(dist_mm) != exp_d[k]) begin errors++; $display("FAIL bnd%0d_dist got %0d want %0d", k, dist_mm, exp_d[k]); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bnd%0d_timeout got %b want 0", k, timeout); end
            wait_idle(3000, ok);
        end
    endtask

    task automatic test_stuck_echo();
        int n; bit ok;
        echo = 1'b1;
        repeat (5) @(negedge CLK);
        start_meas(ok);
        wait_vld(2000, n, ok);
        checks++; if (!ok || n != 1201) begin errors++; $display("FAIL stuck_latency got %0d want 1201", n); end
        checks++; if (timeout !== 1'b1)    begin errors++; $display("FAIL stuck_timeout got %b want 1", timeout); end
        checks++; if (time_us !== 16'd299) begin errors++; $display("FAIL stuck_time got %0d want 299", time_us); end
        echo = 1'b0;
        wait_idle(3000, ok);
    endtask

    task automatic test_period();
        int n, ta, tb; bit ok;
        en = 1'b1;
        wait_trig(1'b1, 10, n, ok);
        ta = cyc;
        wait_trig(1'b0, 100, n, ok);
        repeat (20) @(negedge CLK);
        pulse_echo(40);
        wait_trig(1'b1, 3000, n, ok);
        tb = cyc;
        en = 1'b0;
        checks++; if (!ok || (tb - ta) != 2400) begin errors++; $display("FAIL period_spacing got %0d want 2400", tb - ta); end
        wait_trig(1'b0, 100, n, ok);
        repeat (20) @(negedge CLK);
        pulse_echo(40);
        wait_vld(50, n, ok);
        checks++; if (!ok || time_us !== 16'd10 || dist_mm !== 14'd1 || timeout !== 1'b0) begin
            errors++; $display("FAIL period_result got %0d/%0d/%b want 10/1/0", time_us, dist_mm, timeout);
        end
        wait_idle(3000, ok);
    endtask

    task automatic test_long_echo();
        int n; bit ok;
        start_meas(ok);
        repeat (20) @(negedge CLK);
        echo = 1'b1;
        wait_vld(2000, n, ok);
        checks++; if (!ok || n != 1205) begin errors++; $display("FAIL long_latency got %0d want 1205", n); end
        checks++; if (timeout !== 1'b1)   begin errors++; $display("FAIL long_timeout got %b want 1", timeout); end
        checks++; if (time_us !== 16'd10) begin errors++; $display("FAIL long_time got %0d want 10", time_us); end
        checks++; if (dist_mm !== 14'd1)  begin errors++; $display("FAIL long_dist got %0d want 1", dist_mm); end
        echo = 1'b0;
        wait_idle(3000, ok);
    endtask

    task automatic test_en_drop();
        int n, rises; bit ok;
        en = 1'b1;
        wait_trig(1'b1, 10, n, ok);
        wait_trig(1'b0, 100, n, ok);
        repeat (20) @(negedge CLK);
        echo = 1'b1;
        repeat (100) @(negedge CLK);
        en = 1'b0;
        repeat (100) @(negedge CLK);
        echo = 1'b0;
        wait_vld(50, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_vld got none want pulse"); end
        checks++; if (time_us !== 16'd50 || dist_mm !== 14'd8) begin
            errors++; $display("FAIL endrop_result got %0d/%0d want 50/8", time_us, dist_mm);
        end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_idle got busy want idle"); end
        rises = 0;
        repeat (3000) begin
            @(negedge CLK);
            if (trig === 1'b1) rises++;
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL endrop_retrig got %0d want 0", rises); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_trig();
        test_nominal();
        test_no_echo();
        test_boundary();
        test_stuck_echo();
        test_period();
        test_long_echo();
        test_en_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
